// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file writeback path.
// Entries carry the destination index and the data to commit.
package regfile_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned ADDR_WIDTH = 5;

    localparam logic [ADDR_WIDTH-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Dual-push (ordered), single-pop circular FIFO of pending writebacks.
// Entries are presented in age order (index 0 = head) for the bypass scan.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PtrW = $clog2(DEPTH),
    localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_old,
    input  wb_entry_t             entry_old,
    input  logic                  push_new,
    input  wb_entry_t             entry_new,
    input  logic                  pop,
    output wb_entry_t [DEPTH-1:0] entries,
    output logic      [DEPTH-1:0] valid,
    output logic      [CntW-1:0]  count
);

    wb_entry_t [DEPTH-1:0] mem_q, mem_d;
    logic [PtrW-1:0] wptr_q, wptr_d;
    logic [PtrW-1:0] rptr_q, rptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            do_pop;

    // The older push lands first so a same-cycle pair keeps its order.
    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        do_pop = pop && (count_q != '0);
        if (push_old) begin
            mem_d[wptr_d] = entry_old;
            wptr_d        = wptr_d + PtrW'(1);
        end
        if (push_new) begin
            mem_d[wptr_d] = entry_new;
            wptr_d        = wptr_d + PtrW'(1);
        end
        rptr_d  = do_pop ? rptr_q + PtrW'(1) : rptr_q;
        count_d = count_q + CntW'(push_old) + CntW'(push_new) - CntW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entries[i] = mem_q[rptr_q + PtrW'(i)];
            valid[i]   = CntW'(i) < count_q;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/regfile_write_driver.sv
// Writeback initiator for the register file: arbitrates ALU/load requests into an
// ordered pending queue, drains one write per cycle and bypasses pending data to reads.
module regfile_write_driver
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  aluValid,
    input  logic [ADDR_WIDTH-1:0] aluRd,
    input  logic [DATA_WIDTH-1:0] aluData,
    output logic                  aluReady,
    input  logic                  memValid,
    input  logic [ADDR_WIDTH-1:0] memRd,
    input  logic [DATA_WIDTH-1:0] memData,
    output logic                  memReady,
    output logic                  regWrite,
    output logic [ADDR_WIDTH-1:0] writeRegister,
    output logic [DATA_WIDTH-1:0] writeData,
    input  logic [ADDR_WIDTH-1:0] readRegister1,
    input  logic [ADDR_WIDTH-1:0] readRegister2,
    output logic                  bypassHit1,
    output logic                  bypassHit2,
    output logic [DATA_WIDTH-1:0] bypassData1,
    output logic [DATA_WIDTH-1:0] bypassData2,
    output logic [ADDR_WIDTH-1:0] pendingCount
);

    wb_entry_t [DEPTH-1:0] entries;
    logic      [DEPTH-1:0] valid;
    logic      [CntW-1:0]  count;
    logic      [CntW-1:0]  free;
    logic                  mem_live;
    logic                  mem_push;
    logic                  alu_push;
    wb_entry_t             mem_entry;
    wb_entry_t             alu_entry;

    // Readiness looks only at the registered count; the same-cycle pop is not credited.
    always_comb begin
        free     = CntW'(DEPTH) - count;
        mem_live = memValid && (memRd != REG_ZERO);
        memReady = free >= CntW'(1);
        aluReady = mem_live ? (free >= CntW'(2)) : (free >= CntW'(1));
        mem_push = memValid && memReady && (memRd != REG_ZERO);
        alu_push = aluValid && aluReady && (aluRd != REG_ZERO);
    end

    always_comb begin
        mem_entry.rd   = memRd;
        mem_entry.data = memData;
        alu_entry.rd   = aluRd;
        alu_entry.data = aluData;
    end

    wb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_old (mem_push),
        .entry_old(mem_entry),
        .push_new (alu_push),
        .entry_new(alu_entry),
        .pop      (regWrite),
        .entries  (entries),
        .valid    (valid),
        .count    (count)
    );

    always_comb begin
        regWrite      = count != '0;
        writeRegister = regWrite ? entries[0].rd : '0;
        writeData     = regWrite ? entries[0].data : '0;
        pendingCount  = ADDR_WIDTH'(count);
    end

    // Scanning oldest to youngest lets the youngest match win.
    always_comb begin
        bypassHit1  = 1'b0;
        bypassHit2  = 1'b0;
        bypassData1 = '0;
        bypassData2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (readRegister1 != REG_ZERO) && (entries[i].rd == readRegister1)) begin
                bypassHit1  = 1'b1;
                bypassData1 = entries[i].data;
            end
            if (valid[i] && (readRegister2 != REG_ZERO) && (entries[i].rd == readRegister2)) begin
                bypassHit2  = 1'b1;
                bypassData2 = entries[i].data;
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_driver.sv
// Bench for regfile_write_driver: directed scenarios plus randomized traffic, all
// checked every cycle against a queue-based model of the pending writes.
module tb_regfile_write_driver;

    localparam int Depth = 4;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } req_t;

    logic        clk;
    logic        rst_n;
    logic        aluValid, memValid;
    logic [4:0]  aluRd, memRd;
    logic [31:0] aluData, memData;
    logic        aluReady, memReady;
    logic        regWrite;
    logic [4:0]  writeRegister;
    logic [31:0] writeData;
    logic [4:0]  readRegister1, readRegister2;
    logic        bypassHit1, bypassHit2;
    logic [31:0] bypassData1, bypassData2;
    logic [4:0]  pendingCount;

    regfile_write_driver #(
        .DEPTH(Depth)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .aluValid     (aluValid),
        .aluRd        (aluRd),
        .aluData      (aluData),
        .aluReady     (aluReady),
        .memValid     (memValid),
        .memRd        (memRd),
        .memData      (memData),
        .memReady     (memReady),
        .regWrite     (regWrite),
        .writeRegister(writeRegister),
        .writeData    (writeData),
        .readRegister1(readRegister1),
        .readRegister2(readRegister2),
        .bypassHit1   (bypassHit1),
        .bypassHit2   (bypassHit2),
        .bypassData1  (bypassData1),
        .bypassData2  (bypassData2),
        .pendingCount (pendingCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    req_t model_q[$];
    req_t mem_src[$];
    req_t alu_src[$];
    int   n_cmp;
    int   n_err;
    int   n_writes;
    logic exp_mem_acc, exp_alu_acc;

    function automatic req_t mk(input logic [4:0] rd, input logic [31:0] data);
        req_t r;
        r.rd   = rd;
        r.data = data;
        return r;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected outputs follow from the list of pending writes alone.
    task automatic model_check();
        int          cnt;
        int          free;
        logic        e_mr, e_ar, h1, h2;
        logic [31:0] d1, d2;
        cnt  = model_q.size();
        free = Depth - cnt;
        e_mr = free >= 1;
        e_ar = (memValid && memRd != 0) ? (free >= 2) : (free >= 1);
        h1 = 0; h2 = 0; d1 = 0; d2 = 0;
        foreach (model_q[i]) begin
            if (readRegister1 != 0 && model_q[i].rd == readRegister1) begin
                h1 = 1; d1 = model_q[i].data;
            end
            if (readRegister2 != 0 && model_q[i].rd == readRegister2) begin
                h2 = 1; d2 = model_q[i].data;
            end
        end
        check_eq("memReady", memReady, e_mr);
        check_eq("aluReady", aluReady, e_ar);
        check_eq("pendingCount", pendingCount, cnt);
        check_eq("regWrite", regWrite, cnt != 0);
        check_eq("writeRegister", writeRegister, cnt != 0 ? model_q[0].rd : 5'd0);
        check_eq("writeData", writeData, cnt != 0 ? model_q[0].data : 32'd0);
        check_eq("bypassHit1", bypassHit1, h1);
        check_eq("bypassData1", bypassData1, d1);
        check_eq("bypassHit2", bypassHit2, h2);
        check_eq("bypassData2", bypassData2, d2);
        exp_mem_acc = memValid && e_mr;
        exp_alu_acc = aluValid && e_ar;
        if (cnt != 0) n_writes++;
    endtask

    task automatic model_update();
        if (!rst_n) begin
            model_q.delete();
        end else begin
            if (model_q.size() != 0) void'(model_q.pop_front());
            if (exp_mem_acc) begin
                if (mem_src[0].rd != 0) model_q.push_back(mem_src[0]);
                void'(mem_src.pop_front());
            end
            if (exp_alu_acc) begin
                if (alu_src[0].rd != 0) model_q.push_back(alu_src[0]);
                void'(alu_src.pop_front());
            end
        end
    endtask

    // Entered at a falling edge; sources hold their head request until accepted.
    task automatic run_cycle();
        memValid = rst_n && (mem_src.size() != 0);
        aluValid = rst_n && (alu_src.size() != 0);
        memRd    = memValid ? mem_src[0].rd : 5'($urandom);
        memData  = memValid ? mem_src[0].data : $urandom;
        aluRd    = aluValid ? alu_src[0].rd : 5'($urandom);
        aluData  = aluValid ? alu_src[0].data : $urandom;
        #1;
        model_check();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    initial begin
        int w0;
        n_cmp = 0; n_err = 0; n_writes = 0;
        rst_n = 1'b0;
        aluValid = 0; memValid = 0; aluRd = 0; memRd = 0; aluData = 0; memData = 0;
        readRegister1 = 0; readRegister2 = 0;
        exp_mem_acc = 0; exp_alu_acc = 0;
        @(negedge clk);
        run_cycle();
        run_cycle();
        rst_n = 1'b1;

        // Reset state and idle
        readRegister1 = 5;
        #1;
        check_eq("t1_regWrite", regWrite, 1'b0);
        check_eq("t1_pendingCount", pendingCount, 5'd0);
        check_eq("t1_bypassHit1", bypassHit1, 1'b0);

        // Single ALU write
        alu_src.push_back(mk(5'd3, 32'hDEADBEEF));
        run_cycle();
        #1;
        check_eq("t2_regWrite", regWrite, 1'b1);
        check_eq("t2_writeRegister", writeRegister, 5'd3);
        check_eq("t2_writeData", writeData, 32'hDEADBEEF);
        run_cycle();
        #1;
        check_eq("t2_regWrite_after", regWrite, 1'b0);

        // Dual accept to the same register: memory entry is older
        mem_src.push_back(mk(5'd4, 32'h11));
        alu_src.push_back(mk(5'd4, 32'h22));
        readRegister1 = 4;
        run_cycle();
        #1;
        check_eq("t3_pendingCount", pendingCount, 5'd2);
        check_eq("t3_bypassData1", bypassData1, 32'h22);
        check_eq("t3_first_write", writeData, 32'h11);
        run_cycle();
        #1;
        check_eq("t3_second_write", writeData, 32'h22);
        run_cycle();
        #1;
        check_eq("t3_drained", regWrite, 1'b0);

        // x0 request is handshaken but dropped
        alu_src.push_back(mk(5'd0, 32'h55));
        readRegister1 = 0;
        run_cycle();
        #1;
        check_eq("t4_pendingCount", pendingCount, 5'd0);
        check_eq("t4_regWrite", regWrite, 1'b0);
        check_eq("t4_bypassHit1", bypassHit1, 1'b0);

        // Back-pressure and pointer wrap: 8 writes in order
        n_writes = 0;
        for (int i = 0; i < 4; i++) begin
            mem_src.push_back(mk(5'(i + 1), 32'hA0 + i));
            alu_src.push_back(mk(5'(i + 9), 32'hB0 + i));
        end
        readRegister1 = 2;
        readRegister2 = 10;
        for (int c = 0; c < 40; c++) begin
            if (mem_src.size() == 0 && alu_src.size() == 0 && model_q.size() == 0) break;
            run_cycle();
        end
        #1;
        check_eq("t5_writes", n_writes, 8);
        check_eq("t5_pendingCount", pendingCount, 5'd0);

        // Reset with three writes pending
        mem_src.push_back(mk(5'd1, 32'hC1));
        mem_src.push_back(mk(5'd2, 32'hC2));
        alu_src.push_back(mk(5'd3, 32'hC3));
        alu_src.push_back(mk(5'd5, 32'hC5));
        run_cycle();
        run_cycle();
        #1;
        check_eq("t6_pending_before", pendingCount, 5'd3);
        rst_n = 1'b0;
        run_cycle();
        rst_n = 1'b1;
        #1;
        check_eq("t6_pendingCount", pendingCount, 5'd0);
        check_eq("t6_regWrite", regWrite, 1'b0);
        w0 = n_writes;
        mem_src.delete();
        alu_src.delete();
        for (int c = 0; c < 3; c++) run_cycle();
        check_eq("t6_no_stale_writes", n_writes, w0);

        // Randomized traffic with narrow register range to force collisions
        for (int c = 0; c < 600; c++) begin
            if (mem_src.size() == 0 && ($urandom % 3) == 0)
                mem_src.push_back(mk(5'($urandom % 8), $urandom));
            if (alu_src.size() == 0 && ($urandom % 3) != 0)
                alu_src.push_back(mk(5'($urandom % 8), $urandom));
            readRegister1 = 5'($urandom % 8);
            readRegister2 = 5'($urandom % 8);
            rst_n = ($urandom % 80) != 0;
            run_cycle();
        end
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) run_cycle();
        #1;
        check_eq("final_empty", pendingCount, 5'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
